pipeline_muldiv: RTL and testbench
==================================

// Module: pipeline_muldiv
// PURPOSE
//  Iterative RV32M multiply/divide unit for the execute stage of the 5-stage pipeline.
//  Accepts one op per start_i, holds the front of the pipeline via stall_o while it
//  computes, then presents a one-cycle result and destination register to ex/mem.
//  Parametrised in datapath width. Degenerate divides can take an optional early-out.
// PARAMETERS
//  XLEN       32  operand/result width (even, >=8)
//  REG_AW     5   register address width
//  EARLY_OUT  1   1: div-by-zero/overflow/zero-operand ops finish in 1 cycle; 0: full latency
// PORTS
//  clk_i     in   1       clock, rising edge
//  reset_i   in   1       synchronous, active-high reset
//  start_i   in   1       launch op (sampled only when accepted, see below)
//  flush_i   in   1       abort in-flight op (branch taken / pipeline flush)
//  op_i      in   3       funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  rs1_i     in   XLEN    operand A (dividend / multiplicand)
//  rs2_i     in   XLEN    operand B (divisor / multiplier)
//  rd_i      in   REG_AW  destination register, captured at accept
//  result_o  out  XLEN    result, valid when valid_o
//  rd_o      out  REG_AW  captured destination, valid when valid_o
//  valid_o   out  1       one-cycle result strobe
//  busy_o    out  1       op in flight (state != IDLE)
//  stall_o   out  1       hold fetch/decode/execute pipeline registers
// BEHAVIOUR
//  Reset: state=IDLE; result_o=0, rd_o=0, valid_o=0, busy_o=0, stall_o=0; counter=0.
//  States: IDLE, CALC, DONE.
//   IDLE: start_i & ~flush_i -> accept: latch op, operands, rd; go CALC
//         (or DONE if EARLY_OUT and op is special case).
//   CALC: one iteration per cycle, counter 0..XLEN-1; at XLEN-1 -> DONE.
//   DONE: valid_o=1 for this cycle only; result_o/rd_o hold until next DONE.
//         start_i & ~flush_i in DONE accepted (back-to-back), else -> IDLE.
//  Latency: accept at cycle T -> valid_o at T+XLEN+1; special case T+1.
//  start_i ignored in CALC (no queueing). flush_i in any state -> IDLE next cycle,
//   no valid_o; flush_i wins over simultaneous start_i; flush_i in DONE suppresses
//   valid_o that cycle. reset_i mid-op identical to reset from IDLE.
//  stall_o = (IDLE|DONE) & start_i & ~flush_i, or state==CALC; low in DONE unless a
//   new op is accepted.
//  Multiply: shift-add on |A|,|B| (signedness per op), 2*XLEN-bit product;
//   MUL low XLEN; MULH/MULHSU/MULHU high XLEN; negate product if signs differ
//   (MULH: A,B signed; MULHSU: A signed, B unsigned; MULHU: both unsigned).
//  Divide: restoring, unsigned on magnitudes; quotient negated if signs differ (DIV),
//   remainder takes dividend sign (REM).
//  Special cases (RISC-V, exact): B=0 -> quotient all-ones, remainder = A;
//   signed A=MIN, B=-1 -> quotient MIN, remainder 0. Results identical with EARLY_OUT=0.
//  Operands latched at accept; later changes to rs1_i/rs2_i/op_i/rd_i have no effect.
// TESTING
//  1 MUL 7 x 0xFFFFFFFD, rd=5 -> valid_o at T+33, result 0xFFFFFFEB, rd_o=5, stall_o T..T+32.
//  2 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same -> 0x00000000; MULHSU -> 0xFFFFFFFF.
//  3 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
//  4 DIVU 0x1234 / 0 -> 0xFFFFFFFF at T+1; REMU -> 0x1234; DIV 0x80000000/-1 -> 0x80000000,
//    REM -> 0; repeat with EARLY_OUT=0 -> same values at T+33.
//  5 Start DIV, flush_i at CALC cycle 10 -> IDLE next cycle, no valid_o, stall_o low;
//    flush_i+start_i same cycle -> not accepted; reset_i at cycle 20 -> all outputs 0.
//  6 Back-to-back: MUL accepted in DONE of prior DIV -> one valid per op, start_i during
//    CALC ignored (exactly 2 valid_o pulses), XLEN=16 build passes tests 1-4 scaled.

Source files
------------

// File: rtl/pipeline_muldiv.sv
// pipeline_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply, restoring divide, optional one-cycle degenerate divides.
module pipeline_muldiv #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [2:0]        op_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic [XLEN-1:0]   result_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              stall_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] XMIN =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;

  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   m;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic [REG_AW-1:0] rd_q;
  logic              neg_q;
  logic              rneg_q;
  logic              bz_q;

  logic            a_sgn;
  logic            b_sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            in_div;
  logic            in_rem;
  logic            b_zero;
  logic            ovf;
  logic            early;
  logic [XLEN-1:0] spec_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic              ge;
  logic [XLEN-1:0]   hi_nxt;
  logic [XLEN-1:0]   lo_nxt;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   q_s;
  logic [XLEN-1:0]   r_s;
  logic [XLEN-1:0]   fin_res;

  assign busy_o  = (state != IDLE);
  assign valid_o = (state == DONE) && !flush_i;
  assign stall_o = (state == CALC) ||
                   ((state == IDLE || state == DONE) &&
                    start_i && !flush_i);

  // Decode incoming op: operand signs, magnitudes, degenerate divides
  always_comb begin
    a_sgn = (op_i == 3'd1) || (op_i == 3'd2) ||
            (op_i == 3'd4) || (op_i == 3'd6);
    b_sgn = (op_i == 3'd1) || (op_i == 3'd4) ||
            (op_i == 3'd6);
    in_div = op_i[2];
    in_rem = op_i[2] & op_i[1];
    a_neg = a_sgn & rs1_i[XLEN-1];
    b_neg = b_sgn & rs2_i[XLEN-1];
    a_mag = a_neg ? -rs1_i : rs1_i;
    b_mag = b_neg ? -rs2_i : rs2_i;
    b_zero = (rs2_i == '0);
    ovf = in_div & a_sgn & b_sgn &
          (rs1_i == XMIN) & (&rs2_i);
    early = EARLY_OUT & in_div &
            (b_zero | ovf | (rs1_i == '0));
    spec_res = '0;
    if (b_zero)
      spec_res = in_rem ? rs1_i : '1;
    else if (ovf && !in_rem)
      spec_res = XMIN;
  end

  // One shift-add or restoring-divide iteration, plus final fixup
  always_comb begin
    mul_sum = {1'b0, hi} +
              (lo[0] ? {1'b0, m} : '0);
    rem_sh  = {hi, lo[XLEN-1]};
    ge      = (rem_sh >= {1'b0, m});
    hi_nxt  = '0;
    lo_nxt  = '0;
    if (op_q[2]) begin
      hi_nxt = ge ? (rem_sh[XLEN-1:0] - m)
                  : rem_sh[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], ge};
    end else begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod   = {hi_nxt, lo_nxt};
    prod_s = neg_q ? -prod : prod;
    q_s    = neg_q ? -lo_nxt : lo_nxt;
    r_s    = rneg_q ? -hi_nxt : hi_nxt;
    fin_res = '0;
    unique case (op_q)
      3'd0:    fin_res = prod_s[XLEN-1:0];
      3'd1,
      3'd2,
      3'd3:    fin_res = prod_s[2*XLEN-1:XLEN];
      3'd4,
      3'd5:    fin_res = bz_q ? '1 : q_s;
      default: fin_res = bz_q ? a_q : r_s;
    endcase
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      cnt      <= '0;
      result_o <= '0;
      rd_o     <= '0;
      op_q     <= '0;
      a_q      <= '0;
      m        <= '0;
      hi       <= '0;
      lo       <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bz_q     <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      unique case (state)
        CALC: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= DONE;
            result_o <= fin_res;
            rd_o     <= rd_q;
          end
        end
        default: begin
          if (start_i) begin
            op_q   <= op_i;
            a_q    <= rs1_i;
            rd_q   <= rd_i;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            bz_q   <= b_zero;
            hi     <= '0;
            lo     <= in_div ? a_mag : b_mag;
            m      <= in_div ? b_mag : a_mag;
            cnt    <= '0;
            if (early) begin
              state    <= DONE;
              result_o <= spec_res;
              rd_o     <= rd_i;
            end else begin
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_muldiv.sv
// tb_pipeline_muldiv: directed checks of pipeline_muldiv at XLEN=32
// (early-out on and off) and XLEN=16.
module tb_pipeline_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd;
  int          sel;

  logic        st0, st1, st2;
  logic [31:0] r0, r1;
  logic [15:0] r2;
  logic [4:0]  d0, d1, d2;
  logic        v0, v1, v2;
  logic        b0, b1, b2;
  logic        s0, s1, s2;

  logic [31:0] obs_r;
  logic [4:0]  obs_d;
  logic        obs_v, obs_b, obs_s;

  int n_chk = 0;
  int n_fail = 0;
  int vcount = 0;

  always #5 clk = ~clk;

  assign st0 = start && (sel == 0);
  assign st1 = start && (sel == 1);
  assign st2 = start && (sel == 2);

  pipeline_muldiv #(.XLEN(32), .REG_AW(5), .EARLY_OUT(1'b1)) u_d0 (
    .clk_i(clk), .reset_i(reset), .start_i(st0), .flush_i(flush),
    .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
    .result_o(r0), .rd_o(d0), .valid_o(v0), .busy_o(b0),
    .stall_o(s0));

  pipeline_muldiv #(.XLEN(32), .REG_AW(5), .EARLY_OUT(1'b0)) u_d1 (
    .clk_i(clk), .reset_i(reset), .start_i(st1), .flush_i(flush),
    .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
    .result_o(r1), .rd_o(d1), .valid_o(v1), .busy_o(b1),
    .stall_o(s1));

  pipeline_muldiv #(.XLEN(16), .REG_AW(5), .EARLY_OUT(1'b1)) u_d2 (
    .clk_i(clk), .reset_i(reset), .start_i(st2), .flush_i(flush),
    .op_i(op), .rs1_i(rs1[15:0]), .rs2_i(rs2[15:0]), .rd_i(rd),
    .result_o(r2), .rd_o(d2), .valid_o(v2), .busy_o(b2),
    .stall_o(s2));

  // Route the selected instance to the observation signals
  always_comb begin
    obs_r = r0; obs_d = d0; obs_v = v0; obs_b = b0; obs_s = s0;
    if (sel == 1) begin
      obs_r = r1; obs_d = d1; obs_v = v1; obs_b = b1; obs_s = s1;
    end else if (sel == 2) begin
      obs_r = {16'h0, r2}; obs_d = d2; obs_v = v2;
      obs_b = b2; obs_s = s2;
    end
  end

  // Count result strobes of the selected instance
  always @(negedge clk) begin
    if (obs_v) vcount++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_vec(input int s, input logic [2:0] o,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [4:0] r,
                         input logic [31:0] exp,
                         input int lat);
    int n;
    int st_cnt;
    sel = s;
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; rd = r; start = 1'b1;
    #1;
    st_cnt = obs_s ? 1 : 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = ~o; rs1 = ~a; rs2 = ~b; rd = ~r;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (obs_s) st_cnt++;
    end while (!obs_v && n < 100);
    check($sformatf("lat s%0d op%0d", s, o), n, lat);
    check($sformatf("res s%0d op%0d", s, o), obs_r, exp);
    check($sformatf("rd s%0d op%0d", s, o), {27'h0, obs_d},
          {27'h0, r});
    check($sformatf("stall s%0d op%0d", s, o), st_cnt, lat);
    @(negedge clk);
    check($sformatf("pulse s%0d op%0d", s, o), {31'h0, obs_v}, 0);
    check($sformatf("hold s%0d op%0d", s, o), obs_r, exp);
  endtask

  initial begin
    int n;
    int vb;
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    op = '0; rs1 = '0; rs2 = '0; rd = '0; sel = 0;
    repeat (2) @(negedge clk);
    check("rst_res", obs_r, 0);
    check("rst_rd", {27'h0, obs_d}, 0);
    check("rst_flags", {29'h0, obs_v, obs_b, obs_s}, 0);
    reset = 1'b0;

    run_vec(0, 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33);
    run_vec(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE, 33);
    run_vec(0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h0, 33);
    run_vec(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 33);
    run_vec(0, 3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFD, 33);
    run_vec(0, 3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 33);
    run_vec(0, 3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33);
    run_vec(0, 3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 33);
    run_vec(0, 3'd5, 32'h1234, 32'h0, 5'd10, 32'hFFFFFFFF, 1);
    run_vec(0, 3'd7, 32'h1234, 32'h0, 5'd11, 32'h1234, 1);
    run_vec(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1);
    run_vec(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h0, 1);
    run_vec(0, 3'd4, 32'hFFFFFFF9, 32'h0, 5'd14, 32'hFFFFFFFF, 1);
    run_vec(0, 3'd6, 32'hFFFFFFF9, 32'h0, 5'd15, 32'hFFFFFFF9, 1);

    run_vec(1, 3'd5, 32'h1234, 32'h0, 5'd10, 32'hFFFFFFFF, 33);
    run_vec(1, 3'd7, 32'h1234, 32'h0, 5'd11, 32'h1234, 33);
    run_vec(1, 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 33);
    run_vec(1, 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h0, 33);
    run_vec(1, 3'd4, 32'hFFFFFFF9, 32'h0, 5'd14, 32'hFFFFFFFF, 33);
    run_vec(1, 3'd6, 32'hFFFFFFF9, 32'h0, 5'd15, 32'hFFFFFFF9, 33);

    run_vec(2, 3'd0, 32'd7, 32'hFFFD, 5'd5, 32'hFFEB, 17);
    run_vec(2, 3'd3, 32'hFFFF, 32'hFFFF, 5'd1, 32'hFFFE, 17);
    run_vec(2, 3'd1, 32'hFFFF, 32'hFFFF, 5'd2, 32'h0, 17);
    run_vec(2, 3'd2, 32'hFFFF, 32'hFFFF, 5'd3, 32'hFFFF, 17);
    run_vec(2, 3'd4, 32'hFFF9, 32'd2, 5'd4, 32'hFFFD, 17);
    run_vec(2, 3'd6, 32'hFFF9, 32'd2, 5'd6, 32'hFFFF, 17);
    run_vec(2, 3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 17);
    run_vec(2, 3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 17);
    run_vec(2, 3'd5, 32'h1234, 32'h0, 5'd10, 32'hFFFF, 1);
    run_vec(2, 3'd7, 32'h1234, 32'h0, 5'd11, 32'h1234, 1);
    run_vec(2, 3'd4, 32'h8000, 32'hFFFF, 5'd12, 32'h8000, 1);
    run_vec(2, 3'd6, 32'h8000, 32'hFFFF, 5'd13, 32'h0, 1);

    sel = 0;
    @(negedge clk);
    op = 3'd4; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd20; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    vb = vcount;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'h0, obs_b}, 0);
    check("flush_stall", {31'h0, obs_s}, 0);
    check("flush_valid", {31'h0, obs_v}, 0);
    repeat (40) @(negedge clk);
    check("flush_no_valid", vcount - vb, 0);

    @(negedge clk);
    op = 3'd0; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1; flush = 1'b1;
    #1 check("fs_stall", {31'h0, obs_s}, 0);
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    @(negedge clk);
    check("fs_busy", {31'h0, obs_b}, 0);

    @(negedge clk);
    op = 3'd0; rs1 = 32'd7; rs2 = 32'd9; rd = 5'd21; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_res", obs_r, 0);
    check("mid_rst_rd", {27'h0, obs_d}, 0);
    check("mid_rst_flags", {29'h0, obs_v, obs_b, obs_s}, 0);

    vb = vcount;
    @(negedge clk);
    op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    op = 3'd0; rs1 = 32'd1; rs2 = 32'd1; rd = 5'd30; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!obs_v && n < 100);
    check("b2b_res1", obs_r, 32'd14);
    check("b2b_rd1", {27'h0, obs_d}, 32'd3);
    op = 3'd0; rs1 = 32'd7; rs2 = 32'hFFFFFFFD; rd = 5'd9; start = 1'b1;
    #1 check("b2b_stall", {31'h0, obs_s}, 1);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!obs_v && n < 100);
    check("b2b_lat2", n, 33);
    check("b2b_res2", obs_r, 32'hFFFFFFEB);
    check("b2b_rd2", {27'h0, obs_d}, 32'd9);
    repeat (3) @(negedge clk);
    check("b2b_pulses", vcount - vb, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
